// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave cook timer and magnetron controller.
//
// Keypad BCD entry shifts digits in from the right (mm:ss). Start counts the time down one second
// every TICKS_PER_SEC cycles. Stop or an open door pauses the count, and the magnetron is duty-cycled
// over a POWER_LEVELS-second window.
//
// Optional build macro: COOK_BEEP_EN. When it is defined, beep_o is driven high for BEEP_TICKS
// cycles after the count reaches DONE. When it is undefined, beep_o is tied low and no beep counter
// is built.
//
// Ports:
//   clock_i, reset_i   clock (rising edge) and asynchronous active-high reset
//   keypad_i           one-hot digit keys, bit n = digit n
//   startn_i           start, active low
//   stopn_i            stop/pause, active low
//   clearn_i           clear, active low
//   door_closed_i      1 = door closed
//   power_level_i      requested power level, latched at start
//   sec_ones_o         BCD seconds ones digit
//   sec_tens_o         BCD seconds tens digit
//   min_bcd_o          BCD minutes, digit 0 in [3:0]
//   mag_on_o           magnetron enable
//   cooking_o          high while in COOK
//   done_o             high while in DONE
//   beep_o             end-of-cook beep
module cook_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned MIN_DIGITS    = 1,
  parameter int unsigned POWER_LEVELS  = 10,
  parameter int unsigned PWR_W         = 4,
  parameter int unsigned BEEP_TICKS    = 300
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [9:0]              keypad_i,
  input  logic                    startn_i,
  input  logic                    stopn_i,
  input  logic                    clearn_i,
  input  logic                    door_closed_i,
  input  logic [PWR_W-1:0]        power_level_i,
  output logic [3:0]              sec_ones_o,
  output logic [3:0]              sec_tens_o,
  output logic [4*MIN_DIGITS-1:0] min_bcd_o,
  output logic                    mag_on_o,
  output logic                    cooking_o,
  output logic                    done_o,
  output logic                    beep_o
);

  localparam int unsigned PrescW = $clog2(TICKS_PER_SEC);
  localparam int unsigned MinW   = 4 * MIN_DIGITS;

  typedef enum logic [2:0] {StIdle, StSet, StCook, StPause, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        sec_ones_q, sec_ones_d;
  logic [3:0]        sec_tens_q, sec_tens_d;
  logic [MinW-1:0]   min_q, min_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [PWR_W-1:0]  duty_q, duty_d;
  logic [PWR_W-1:0]  power_q, power_d;
  logic              kp_idle_q, kp_idle_d;

  // Key decode: only a clean press (one-hot after an all-zero cycle) is accepted.
  logic       key_valid;
  logic [3:0] key_digit;

  always_comb begin
    key_digit = 4'd0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (keypad_i[i]) key_digit = 4'(i);
    end
    key_valid = kp_idle_q && $onehot(keypad_i);
  end

  // Digit shift for key entry; the top minute digit falls off.
  logic [MinW-1:0] sh_min;
  logic            sh_zero;

  always_comb begin
    sh_min      = '0;
    sh_min[3:0] = sec_tens_q;
    for (int unsigned i = 1; i < MIN_DIGITS; i++) begin
      sh_min[4*i+:4] = min_q[4*(i-1)+:4];
    end
    sh_zero = (sh_min == '0) && (sec_ones_q == 4'd0) && (key_digit == 4'd0);
  end

  // One-second decrement with BCD borrows. Seconds tens borrow back to 5, so entered values above
  // 59 simply run down as they are.
  logic [3:0]      dec_ones, dec_tens;
  logic [MinW-1:0] dec_min;
  logic            borrow;
  logic            dec_zero;

  always_comb begin
    dec_ones = sec_ones_q;
    dec_tens = sec_tens_q;
    dec_min  = min_q;
    borrow   = 1'b0;
    if (sec_ones_q != 4'd0) begin
      dec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        borrow   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (min_q[4*i+:4] == 4'd0) begin
          dec_min[4*i+:4] = 4'd9;
        end else begin
          dec_min[4*i+:4] = min_q[4*i+:4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_min == '0);
  end

  logic [PWR_W-1:0] power_clamped;
  assign power_clamped = ((power_level_i == '0) || (power_level_i > PWR_W'(POWER_LEVELS))) ?
                         PWR_W'(POWER_LEVELS) : power_level_i;

  // Next state. Priority: clear > door open > stop > start.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_d      = min_q;
    presc_d    = presc_q;
    duty_d     = duty_q;
    power_d    = power_q;
    kp_idle_d  = (keypad_i == '0);

    if (!clearn_i) begin
      state_d    = StIdle;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_d      = '0;
      presc_d    = '0;
      duty_d     = '0;
    end else begin
      case (state_q)
        StIdle, StSet: begin
          if ((state_q == StSet) && door_closed_i && stopn_i && !startn_i) begin
            state_d = StCook;
            presc_d = '0;
            duty_d  = '0;
            power_d = power_clamped;
          end else if (key_valid) begin
            min_d      = sh_min;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_digit;
            state_d    = sh_zero ? StIdle : StSet;
          end
        end
        StCook: begin
          if (!door_closed_i || !stopn_i) begin
            state_d = StPause;
          end else if (presc_q == PrescW'(TICKS_PER_SEC - 1)) begin
            presc_d    = '0;
            sec_ones_d = dec_ones;
            sec_tens_d = dec_tens;
            min_d      = dec_min;
            duty_d     = (duty_q == PWR_W'(POWER_LEVELS - 1)) ? '0 : duty_q + 1'b1;
            if (dec_zero) state_d = StDone;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StPause: begin
          if (door_closed_i && stopn_i && !startn_i) state_d = StCook;
        end
        StDone: begin
          if (!door_closed_i) begin
            state_d = StIdle;
            presc_d = '0;
            duty_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_q      <= '0;
      presc_q    <= '0;
      duty_q     <= '0;
      power_q    <= '0;
      kp_idle_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_q      <= min_d;
      presc_q    <= presc_d;
      duty_q     <= duty_d;
      power_q    <= power_d;
      kp_idle_q  <= kp_idle_d;
    end
  end

  assign sec_ones_o = sec_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign min_bcd_o  = min_q;
  assign cooking_o  = (state_q == StCook);
  assign done_o     = (state_q == StDone);
  // The door term is deliberately combinational so that opening the door cuts the magnetron at once.
  assign mag_on_o   = (state_q == StCook) && (duty_q < power_q) && door_closed_i;

`ifdef COOK_BEEP_EN
  localparam int unsigned BeepW = $clog2(BEEP_TICKS + 1);

  logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (state_d != StDone) begin
      beep_cnt_d = '0;
    end else if (state_q != StDone) begin
      beep_cnt_d = BeepW'(BEEP_TICKS);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) beep_cnt_q <= '0;
    else         beep_cnt_q <= beep_cnt_d;
  end

  assign beep_o = (beep_cnt_q != '0);
`else
  assign beep_o = 1'b0;
`endif

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Randomised bench for cook_timer_ctrl against a behavioural timer model.
module tb_cook_timer_ctrl;

  localparam int unsigned Tps         = 4;
  localparam int unsigned MinDigits   = 1;
  localparam int unsigned PowerLevels = 10;
  localparam int unsigned PwrW        = 4;
  localparam int unsigned BeepTicks   = 6;

  localparam int SIdle  = 0;
  localparam int SSet   = 1;
  localparam int SCook  = 2;
  localparam int SPause = 3;
  localparam int SDone  = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [9:0]             keypad;
  logic                   startn, stopn, clearn, door_closed;
  logic [PwrW-1:0]        power_level;
  logic [3:0]             sec_ones, sec_tens;
  logic [4*MinDigits-1:0] min_bcd;
  logic                   mag_on, cooking, done, beep;

  cook_timer_ctrl #(
    .TICKS_PER_SEC(Tps),
    .MIN_DIGITS   (MinDigits),
    .POWER_LEVELS (PowerLevels),
    .PWR_W        (PwrW),
    .BEEP_TICKS   (BeepTicks)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .keypad_i     (keypad),
    .startn_i     (startn),
    .stopn_i      (stopn),
    .clearn_i     (clearn),
    .door_closed_i(door_closed),
    .power_level_i(power_level),
    .sec_ones_o   (sec_ones),
    .sec_tens_o   (sec_tens),
    .min_bcd_o    (min_bcd),
    .mag_on_o     (mag_on),
    .cooking_o    (cooking),
    .done_o       (done),
    .beep_o       (beep)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: time held as integer minutes plus two seconds digits.
  int m_state, m_min, m_tens, m_ones, m_ticks, m_secs_cooked, m_pwr, m_done_age;
  bit m_prev_zero;

  task automatic model_reset();
    m_state = SIdle; m_min = 0; m_tens = 0; m_ones = 0;
    m_ticks = 0; m_secs_cooked = 0; m_pwr = 0; m_done_age = 0;
    m_prev_zero = 1'b1;
  endtask

  function automatic int min_to_bcd(input int m);
    int r = 0;
    for (int i = 0; i < int'(MinDigits); i++) begin
      r += (m % 10) << (4 * i);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    bit key_ok;
    int kd = 0;
    key_ok = m_prev_zero && ($countones(keypad) == 1);
    for (int i = 0; i < 10; i++) if (keypad[i]) kd = i;
    m_prev_zero = (keypad == 10'd0);
    if (!clearn) begin
      m_state = SIdle; m_min = 0; m_tens = 0; m_ones = 0;
      m_ticks = 0; m_secs_cooked = 0;
      return;
    end
    case (m_state)
      SIdle, SSet: begin
        if (m_state == SSet && door_closed && stopn && !startn) begin
          m_state = SCook; m_ticks = 0; m_secs_cooked = 0;
          m_pwr = (power_level == 0 || power_level > PowerLevels) ? PowerLevels : int'(power_level);
        end else if (key_ok) begin
          m_min  = (m_min * 10 + m_tens) % (10 ** MinDigits);
          m_tens = m_ones;
          m_ones = kd;
          m_state = (m_min == 0 && m_tens == 0 && m_ones == 0) ? SIdle : SSet;
        end
      end
      SCook: begin
        if (!door_closed || !stopn) begin
          m_state = SPause;
        end else begin
          m_ticks++;
          if (m_ticks == Tps) begin
            m_ticks = 0;
            m_secs_cooked++;
            if (m_ones > 0) m_ones--;
            else if (m_tens > 0) begin m_tens--; m_ones = 9; end
            else begin m_min--; m_tens = 5; m_ones = 9; end
            if (m_min == 0 && m_tens == 0 && m_ones == 0) begin
              m_state = SDone; m_done_age = 0;
            end
          end
        end
      end
      SPause: if (door_closed && stopn && !startn) m_state = SCook;
      SDone: begin
        if (!door_closed) begin
          m_state = SIdle; m_ticks = 0; m_secs_cooked = 0;
        end else begin
          m_done_age++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    int exp_mag, exp_beep;
    exp_mag = (m_state == SCook && (m_secs_cooked % PowerLevels) < m_pwr && door_closed) ? 1 : 0;
`ifdef COOK_BEEP_EN
    exp_beep = (m_state == SDone && m_done_age < BeepTicks) ? 1 : 0;
`else
    exp_beep = 0;
`endif
    check("sec_ones", sec_ones, m_ones);
    check("sec_tens", sec_tens, m_tens);
    check("min_bcd", min_bcd, min_to_bcd(m_min));
    check("cooking", cooking, m_state == SCook);
    check("done", done, m_state == SDone);
    check("mag_on", mag_on, exp_mag);
    check("beep", beep, exp_beep);
  endtask

  // One clock: drive at the falling edge, check settled outputs, then advance the model.
  task automatic step(input logic [9:0] kp, input logic st, input logic sp, input logic cl,
                      input logic dr, input logic [PwrW-1:0] pw);
    @(negedge clock);
    keypad = kp; startn = st; stopn = sp; clearn = cl; door_closed = dr; power_level = pw;
    #1;
    compare_all();
    model_step();
  endtask

  task automatic idle(input int n, input logic [PwrW-1:0] pw);
    for (int i = 0; i < n; i++) step(10'd0, 1'b1, 1'b1, 1'b1, 1'b1, pw);
  endtask

  task automatic press(input int d);
    logic [9:0] kp;
    kp = 10'd1 << d;
    step(kp, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
    step(10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
  endtask

  task automatic start(input logic [PwrW-1:0] pw);
    step(10'd0, 1'b0, 1'b1, 1'b1, 1'b1, pw);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    power_level = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [9:0] kp_prev;
    logic [9:0] kp;
    do_reset();
    #1;
    check("rst_ones", sec_ones, 0);
    check("rst_tens", sec_tens, 0);
    check("rst_min", min_bcd, 0);
    check("rst_mag", mag_on, 0);
    check("rst_done", done, 0);

    // Entry 6,0,1 then cook at full power.
    press(6); press(0); press(1);
    #1;
    check("entry_601", {min_bcd, sec_tens, sec_ones}, 12'h601);
    start(4'd10);
    idle(12, 4'd10);
    step(10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10);

    // 1,2,3,4 shifts 1 out; a held key and a two-bit press.
    press(1); press(2); press(3); press(4);
    #1;
    check("entry_234", {min_bcd, sec_tens, sec_ones}, 12'h234);
    for (int i = 0; i < 3; i++) step(10'd1 << 5, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
    step(10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
    step(10'b0000100100, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
    idle(2, 4'd10);
    step(10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10);

    // 0:55, pause by door, resume.
    press(0); press(5); press(5);
    start(4'd10);
    idle(20, 4'd10);
    for (int i = 0; i < 3; i++) step(10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd10);
    start(4'd10);
    idle(10, 4'd10);
    step(10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10);

    // 0:02 at power 3 runs to DONE, then the door opens.
    press(0); press(2);
    start(4'd3);
    idle(18, 4'd3);
    step(10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
    idle(2, 4'd3);

    // 1:10, clear together with start.
    press(1); press(1); press(0);
    start(4'd0);
    idle(6, 4'd0);
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    idle(2, 4'd0);

    // Asynchronous reset mid-cook, then start while idle.
    press(3);
    start(4'd10);
    idle(5, 4'd10);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_mag", mag_on, 0);
    check("areset_cooking", cooking, 0);
    check("areset_digits", {min_bcd, sec_tens, sec_ones}, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    start(4'd10);
    idle(2, 4'd10);

    // Random phase.
    kp_prev = '0;
    for (int n = 0; n < 15000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) kp = kp_prev;
      else if (r < 70) kp = '0;
      else if (r < 95) kp = 10'd1 << $urandom_range(0, 9);
      else kp = 10'($urandom);
      kp_prev = kp;
      step(kp,
           ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
           ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1,
           PwrW'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
